// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: FSM states,
// opcodes, ALUOp / ALUControl / ImmSrc codes and the ImmSrc decode helper.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format for the sign extender, independent of FSM state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Only R-type with funct7b5 set subtracts; addi with funct7b5 set still adds.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core. Sequences fetch, decode,
// memory, execute and writeback over 3-5 cycles, stalling on mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_wr;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       illegal;

    // State register with asynchronous return to the reset state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= state_t'(RESET_STATE);
        else       state <= state_next;
    end

    // Next-state selection and Moore outputs (mem_ready / Zero gate the strobes).
    always_comb begin
        state_next = S_FETCH;
        alu_op     = ALUOP_ADD;
        pc_wr      = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        illegal    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_wr      = mem_ready;
                pc_wr      = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                reg_wr     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_wr     = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_SUB;
                pc_wr      = Zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_wr      = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Strobes are masked by reset itself so they drop without waiting for a clock.
    assign PCWrite    = pc_wr   & ~reset;
    assign MemWrite   = mem_wr  & ~reset;
    assign IRWrite    = ir_wr   & ~reset;
    assign RegWrite   = reg_wr  & ~reset;
    assign illegal_op = illegal & ~reset;
    assign ImmSrc     = imm_src_for(op);
    assign state_o    = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RISC-V core; it replaces the single-cycle main decoder.
- Sequences the shared datapath (PC, instruction/data memory port, ALU, register file, sign extender) over 3-5 cycles per instruction.
- Drives ImmSrc for the sign extender and stalls on a memory-ready handshake.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register enable (also latches OldPC).
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  2  sign extender select: 00 I, 01 S, 10 B, 11 J.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state, for debug and the bench.

Behaviour:
- State register: asynchronous reset to FETCH.
- All outputs are combinational functions of state and inputs (Moore outputs, with mem_ready/Zero gating where noted).
- Every output not listed for a state is 0.
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0.
- ImmSrc is decoded from op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other op -> 00.

State encoding and per-state actions:
- FETCH (0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCWrite = mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by op:
  - lw/sw -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - else -> FETCH, with illegal_op=1 for this cycle.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD (3): AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1 -> FETCH.
- EXECR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ (9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
- JAL (10): ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 -> ALUWB.
- Unused encodings 11-15 go to FETCH on the next edge; no outputs are asserted in them.

ALU decode (ALUOp is internal, 2 bits):
- ALUOp 00 -> add; 01 -> sub.
- ALUOp 10, by funct3:
  - 000 -> sub if {op[5], funct7b5}=11, else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - other -> add.

Latency (mem_ready tied high): lw 5 cycles; sw, R, I and jal 4; beq 3.

Reset asserted mid-instruction: the FSM returns to FETCH immediately and any pending write strobe drops asynchronously.

Decomposition:
- Shared package holds:
  - state encodings
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp codes, ALUControl codes, ImmSrc codes.
- One natural combinational sub-module: alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl).

Test Plan:
- Reset: assert reset mid-MEMWRITE -> state_o=0 and MemWrite=0 without waiting for a clock edge; release with mem_ready=1 -> FETCH asserts IRWrite=1, PCWrite=1.
- lw: op=0000011, mem_ready=1 -> states 0,1,2,3,4 (5 cycles); MEMWB has ResultSrc=01, RegWrite=1; ImmSrc=00 throughout.
- sw with stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite held for 4 cycles, then FETCH; ImmSrc=01.
- R-type sub: op=0110011, funct3=000, funct7b5=1 -> EXECR with ALUControl=001, then ALUWB with RegWrite=1. Repeat with op=0010011, funct7b5=1 -> ALUControl=000 (addi).
- beq: op=1100011 -> ImmSrc=10; with Zero=1 PCWrite=1 in BEQ, with Zero=0 PCWrite=0; returns to FETCH after 3 cycles.
- jal / illegal: op=1101111 -> ImmSrc=11, PCWrite=1 in JAL, then ALUWB writes. op=1110011 -> illegal_op pulses for 1 cycle in DECODE, then FETCH.
